id_stage_pipe: RTL and testbench
================================

Name: id_stage_pipe

Overview:
Parametrised successor to the single-cycle instruction-decode stage. It decodes the instruction, reads an internal register file, and sign-extends the immediate. All results are captured in an ID/EX pipeline register with a valid bit. It also detects load-use hazards, stalls IF, inserts bubbles, and honours downstream hold and flush requests. It sits between the IF/ID register and the EX stage of the 5-stage MIPS pipeline.

Parameters:
DATA_W, 32, register/data width; the immediate is sign-extended to DATA_W
REG_ADDR_W, 5, register-index width
NUM_REGS, 32, register-file depth; must be <= 2**REG_ADDR_W; indices >= NUM_REGS read 0 and ignore writes

Ports:
clk  in  1  clock; all state updates on posedge
rstn  in  1  synchronous reset, active-high (asserted = 1, despite the name)
i_valid  in  1  i_ins/i_npc hold a real instruction
i_ins  in  32  instruction word
i_npc  in  DATA_W  PC+4 of i_ins
i_hold  in  1  EX cannot accept; ID/EX register must freeze
i_flush  in  1  kill the instruction entering ID/EX (taken branch)
wb_regwrite  in  1  write-back enable
wb_reg  in  REG_ADDR_W  write-back register index
wb_data  in  DATA_W  write-back data
o_stall  out  1  combinational; IF/ID must hold its contents this cycle
o_valid  out  1  ID/EX holds a real instruction
o_wb  out  2  {MemtoReg, RegWrite}
o_mem  out  3  {MemRead, MemWrite, Branch}
o_ex  out  4  {ALUOp[1:0], ALUSrc, RegDst}
o_rd1, o_rd2  out  DATA_W  register reads of rs and rt
o_imm  out  DATA_W  sign-extended ins[15:0]
o_rs, o_rt, o_rd  out  REG_ADDR_W  ins[25:21], ins[20:16], ins[15:11] (zero-extended or truncated to REG_ADDR_W)
o_npc  out  DATA_W  registered i_npc

Behaviour:
- Decode is combinational and keyed on ins[31:26]. Fields below are listed as WB / MEM / EX.
  - 000000 (R-type): WB 01, MEM 000, EX 1001.
  - 100011 (lw): WB 11, MEM 100, EX 0010.
  - 101011 (sw): WB 00, MEM 010, EX 0010.
  - 000100 (beq): WB 00, MEM 001, EX 0100.
  - Any other opcode: all zero (NOP).
- Register file:
  - Two async read ports, one sync write port.
  - Write on posedge when wb_regwrite and wb_reg != 0.
  - Register 0 always reads 0.
- Load-use hazard:
  - load_use = i_valid & o_valid & o_mem[2] & (o_rt != 0) & (o_rt == ins[25:21] | o_rt == ins[20:16]).
  - rt is compared even for opcodes that do not read it.
- o_stall = load_use | i_hold.
- ID/EX update priority on each posedge, highest first:
  1. rstn: all outputs 0, all registers 0.
  2. i_flush: load a bubble (o_valid=0, o_wb/o_mem/o_ex = 0; data fields don't-care, driven 0).
  3. i_hold: keep every output unchanged.
  4. load_use: load a bubble.
  5. Otherwise: capture decode/read results; o_valid = i_valid; control fields are zeroed when i_valid=0.
- Latency: 1 cycle from i_ins to the ID/EX outputs.
- Bubble length: a load-use stall lasts exactly 1 cycle. Afterwards the load has moved on, so load_use deasserts.
- i_flush together with i_hold: the flush wins and the bubble is loaded. o_stall still follows i_hold.
- Reset mid-stall: the next cycle has o_valid=0, so o_stall = i_hold only.
- Register writes during reset are ignored. The register file is cleared by reset.

Optional Feature:
ID_WB_BYPASS_EN
- Defined: a read port whose address equals wb_reg, while wb_regwrite=1 and wb_reg != 0, returns wb_data in the same cycle (write-through). This removes the WB→ID hazard.
- Undefined: the read returns the pre-write value. The new value is visible from the next cycle; the hazard is covered externally.

Test Plan:
1. Reset: hold rstn=1 for 2 cycles with random inputs -> every output is 0 and o_stall = i_hold.
2. R-type: write r1=5 and r2=7 via WB, then i_ins=0x00221820 (add r3,r1,r2), i_valid=1 -> next cycle o_valid=1, o_ex=1001, o_wb=01, o_rd1=5, o_rd2=7, o_rd=3, o_rt=2.
3. lw sign-extend: i_ins=0x8C22FFFC (lw r2,-4(r1)) -> o_mem=100, o_ex=0010, o_imm=0xFFFFFFFC.
4. Load-use: lw r2,0(r1) followed by add r3,r2,r4 -> in the second cycle o_stall=1; the next ID/EX holds a bubble (o_valid=0); the add is captured one cycle later.
5. Hold and flush: assert i_hold for 3 cycles -> outputs frozen, o_stall=1 throughout. Assert i_hold and i_flush together -> bubble loaded.
6. Bypass: wb_regwrite=1, wb_reg=1, wb_data=0xABCD in the same cycle as an add reading r1 -> o_rd1=0xABCD with ID_WB_BYPASS_EN defined, the old r1 value without it. A write to r0 is always ignored and r0 reads 0.

Source files
------------

// File: rtl/id_stage_pipe.sv
// Pipelined MIPS instruction-decode stage: decode, register file, sign extension and ID/EX register.
// Define ID_WB_BYPASS_EN to forward same-cycle write-back data to the read ports.
module id_stage_pipe #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_valid,
  input  logic [31:0]           i_ins,
  input  logic [DATA_W-1:0]     i_npc,
  input  logic                  i_hold,
  input  logic                  i_flush,
  input  logic                  wb_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_reg,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  o_stall,
  output logic                  o_valid,
  output logic [1:0]            o_wb,
  output logic [2:0]            o_mem,
  output logic [3:0]            o_ex,
  output logic [DATA_W-1:0]     o_rd1,
  output logic [DATA_W-1:0]     o_rd2,
  output logic [DATA_W-1:0]     o_imm,
  output logic [REG_ADDR_W-1:0] o_rs,
  output logic [REG_ADDR_W-1:0] o_rt,
  output logic [REG_ADDR_W-1:0] o_rd,
  output logic [DATA_W-1:0]     o_npc
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam int FIELD_W = (REG_ADDR_W < 5) ? REG_ADDR_W : 5;
  localparam logic [REG_ADDR_W:0] NUM_REGS_EXT = (REG_ADDR_W + 1)'(NUM_REGS);

  logic [DATA_W-1:0]     regs [NUM_REGS];
  logic [REG_ADDR_W-1:0] rs_idx, rt_idx, rd_idx;
  logic [1:0]            dec_wb;
  logic [2:0]            dec_mem;
  logic [3:0]            dec_ex;
  logic [DATA_W-1:0]     rd1_val, rd2_val, imm_val;
  logic                  load_use;

  // Register fields are zero-extended or truncated to the configured index width.
  always_comb begin
    rs_idx = '0;
    rt_idx = '0;
    rd_idx = '0;
    for (int b = 0; b < FIELD_W; b++) begin
      rs_idx[b] = i_ins[21+b];
      rt_idx[b] = i_ins[16+b];
      rd_idx[b] = i_ins[11+b];
    end
  end

  always_comb begin
    dec_wb  = 2'b00;
    dec_mem = 3'b000;
    dec_ex  = 4'b0000;
    case (i_ins[31:26])
      OP_RTYPE: begin dec_wb = 2'b01; dec_mem = 3'b000; dec_ex = 4'b1001; end
      OP_LW:    begin dec_wb = 2'b11; dec_mem = 3'b100; dec_ex = 4'b0010; end
      OP_SW:    begin dec_wb = 2'b00; dec_mem = 3'b010; dec_ex = 4'b0010; end
      OP_BEQ:   begin dec_wb = 2'b00; dec_mem = 3'b001; dec_ex = 4'b0100; end
      default:  begin dec_wb = 2'b00; dec_mem = 3'b000; dec_ex = 4'b0000; end
    endcase
  end

  assign imm_val = {{(DATA_W-16){i_ins[15]}}, i_ins[15:0]};

  // Register 0 and out-of-range indices always read as zero.
  always_comb begin
    rd1_val = '0;
    rd2_val = '0;
    if (rs_idx != '0 && {1'b0, rs_idx} < NUM_REGS_EXT) begin
`ifdef ID_WB_BYPASS_EN
      if (wb_regwrite && wb_reg == rs_idx) rd1_val = wb_data;
      else rd1_val = regs[rs_idx];
`else
      rd1_val = regs[rs_idx];
`endif
    end
    if (rt_idx != '0 && {1'b0, rt_idx} < NUM_REGS_EXT) begin
`ifdef ID_WB_BYPASS_EN
      if (wb_regwrite && wb_reg == rt_idx) rd2_val = wb_data;
      else rd2_val = regs[rt_idx];
`else
      rd2_val = regs[rt_idx];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else if (wb_regwrite && wb_reg != '0 && {1'b0, wb_reg} < NUM_REGS_EXT) begin
      regs[wb_reg] <= wb_data;
    end
  end

  // rt of the load in ID/EX is compared against both fields regardless of opcode.
  assign load_use = i_valid & o_valid & o_mem[2] & (o_rt != '0) &
                    ((o_rt == rs_idx) | (o_rt == rt_idx));
  assign o_stall  = load_use | i_hold;

  // Reset, flush and load-use bubbles all clear the register; flush overrides hold.
  always_ff @(posedge clk) begin
    if (rstn || i_flush || (!i_hold && load_use)) begin
      o_valid <= 1'b0;
      o_wb    <= '0;
      o_mem   <= '0;
      o_ex    <= '0;
      o_rd1   <= '0;
      o_rd2   <= '0;
      o_imm   <= '0;
      o_rs    <= '0;
      o_rt    <= '0;
      o_rd    <= '0;
      o_npc   <= '0;
    end else if (!i_hold) begin
      o_valid <= i_valid;
      o_wb    <= i_valid ? dec_wb  : 2'b00;
      o_mem   <= i_valid ? dec_mem : 3'b000;
      o_ex    <= i_valid ? dec_ex  : 4'b0000;
      o_rd1   <= rd1_val;
      o_rd2   <= rd2_val;
      o_imm   <= imm_val;
      o_rs    <= rs_idx;
      o_rt    <= rt_idx;
      o_rd    <= rd_idx;
      o_npc   <= i_npc;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Randomised self-checking bench for id_stage_pipe against a behavioural pipeline model.
// Honours ID_WB_BYPASS_EN the same way as the design.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rstn, i_valid, i_hold, i_flush, wb_regwrite;
  logic [31:0] i_ins, i_npc, wb_data;
  logic [4:0]  wb_reg;
  logic        o_stall, o_valid;
  logic [1:0]  o_wb;
  logic [2:0]  o_mem;
  logic [3:0]  o_ex;
  logic [31:0] o_rd1, o_rd2, o_imm, o_npc;
  logic [4:0]  o_rs, o_rt, o_rd;

  id_stage_pipe dut (
    .clk(clk), .rstn(rstn), .i_valid(i_valid), .i_ins(i_ins), .i_npc(i_npc),
    .i_hold(i_hold), .i_flush(i_flush), .wb_regwrite(wb_regwrite),
    .wb_reg(wb_reg), .wb_data(wb_data), .o_stall(o_stall), .o_valid(o_valid),
    .o_wb(o_wb), .o_mem(o_mem), .o_ex(o_ex), .o_rd1(o_rd1), .o_rd2(o_rd2),
    .o_imm(o_imm), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_npc(o_npc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit checking = 1'b0;

  // Model of what the ID/EX register should hold, plus the architectural register file.
  logic [31:0] mregs [32];
  logic        e_valid = 1'b0;
  logic [8:0]  e_ctrl = '0;
  logic [31:0] e_rd1 = '0, e_rd2 = '0, e_imm = '0, e_npc = '0;
  logic [4:0]  e_rs = '0, e_rt = '0, e_rd = '0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] ctrl_of(input logic [5:0] op);
    case (op)
      6'b000000: return {2'b01, 3'b000, 4'b1001};
      6'b100011: return {2'b11, 3'b100, 4'b0010};
      6'b101011: return {2'b00, 3'b010, 4'b0010};
      6'b000100: return {2'b00, 3'b001, 4'b0100};
      default:   return 9'd0;
    endcase
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
`ifdef ID_WB_BYPASS_EN
    if (wb_regwrite && wb_reg == idx) return wb_data;
`endif
    return mregs[idx];
  endfunction

  task automatic applyStimulus(input logic rst, input logic v, input logic [31:0] ins,
                               input logic hold, input logic flush, input logic wr,
                               input logic [4:0] wreg, input logic [31:0] wdata);
    rstn = rst; i_valid = v; i_ins = ins; i_hold = hold; i_flush = flush;
    wb_regwrite = wr; wb_reg = wreg; wb_data = wdata; i_npc = $urandom;
    #2;
  endtask

  task automatic advance();
    logic lu, stall;
    logic [31:0] r1, r2;
    lu = i_valid && e_valid && e_ctrl[6] && e_rt != 5'd0 &&
         (e_rt == i_ins[25:21] || e_rt == i_ins[20:16]);
    stall = lu || i_hold;
    if (checking) begin
      checkOutput("stall", 64'(o_stall), 64'(stall));
      checkOutput("valid", 64'(o_valid), 64'(e_valid));
      checkOutput("ctrl",  64'({o_wb, o_mem, o_ex}), 64'(e_ctrl));
      checkOutput("rd1",   64'(o_rd1), 64'(e_rd1));
      checkOutput("rd2",   64'(o_rd2), 64'(e_rd2));
      checkOutput("imm",   64'(o_imm), 64'(e_imm));
      checkOutput("rs",    64'(o_rs),  64'(e_rs));
      checkOutput("rt",    64'(o_rt),  64'(e_rt));
      checkOutput("rd",    64'(o_rd),  64'(e_rd));
      checkOutput("npc",   64'(o_npc), 64'(e_npc));
    end
    r1 = mread(i_ins[25:21]);
    r2 = mread(i_ins[20:16]);
    @(posedge clk);
    if (rstn || i_flush || (!i_hold && lu)) begin
      e_valid = 1'b0; e_ctrl = '0; e_rd1 = '0; e_rd2 = '0; e_imm = '0;
      e_npc = '0; e_rs = '0; e_rt = '0; e_rd = '0;
    end else if (!i_hold) begin
      e_valid = i_valid;
      e_ctrl  = i_valid ? ctrl_of(i_ins[31:26]) : 9'd0;
      e_rd1 = r1; e_rd2 = r2;
      e_imm = 32'($signed(i_ins[15:0]));
      e_rs = i_ins[25:21]; e_rt = i_ins[20:16]; e_rd = i_ins[15:11];
      e_npc = i_npc;
    end
    if (rstn) begin
      for (int r = 0; r < 32; r++) mregs[r] = '0;
    end else if (wb_regwrite && wb_reg != 5'd0) begin
      mregs[wb_reg] = wb_data;
    end
    #1;
    checking = 1'b1;
  endtask

  function automatic logic [31:0] rand_ins();
    logic [5:0] op;
    case ($urandom_range(0, 4))
      0: op = 6'b000000;
      1: op = 6'b100011;
      2: op = 6'b101011;
      3: op = 6'b000100;
      default: op = 6'($urandom);
    endcase
    return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 11'($urandom)};
  endfunction

  initial begin
    logic [31:0] exp_bypass;
    for (int r = 0; r < 32; r++) mregs[r] = '0;

    // Reset held for two cycles with random inputs.
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b1, 1'($urandom), rand_ins(), 1'($urandom), 1'($urandom),
                    1'b1, 5'($urandom), $urandom);
      advance();
    end
    checkOutput("rst_valid", 64'(o_valid), 64'd0);
    checkOutput("rst_rd1", 64'(o_rd1), 64'd0);

    // R-type after loading r1 and r2.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd1, 32'd5); advance();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd2, 32'd7); advance();
    applyStimulus(1'b0, 1'b1, 32'h00221820, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0); advance();
    checkOutput("tp2_valid", 64'(o_valid), 64'd1);
    checkOutput("tp2_ex", 64'(o_ex), 64'h9);
    checkOutput("tp2_wb", 64'(o_wb), 64'h1);
    checkOutput("tp2_rd1", 64'(o_rd1), 64'd5);
    checkOutput("tp2_rd2", 64'(o_rd2), 64'd7);
    checkOutput("tp2_rd", 64'(o_rd), 64'd3);
    checkOutput("tp2_rt", 64'(o_rt), 64'd2);

    // lw with a negative offset.
    applyStimulus(1'b0, 1'b1, 32'h8C22FFFC, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0); advance();
    checkOutput("tp3_mem", 64'(o_mem), 64'h4);
    checkOutput("tp3_ex", 64'(o_ex), 64'h2);
    checkOutput("tp3_imm", 64'(o_imm), 64'hFFFFFFFC);

    // Load-use: lw r2,0(r1) then add r3,r2,r4.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0); advance();
    applyStimulus(1'b0, 1'b1, 32'h8C220000, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0); advance();
    applyStimulus(1'b0, 1'b1, 32'h00441820, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    checkOutput("tp4_stall", 64'(o_stall), 64'd1);
    advance();
    checkOutput("tp4_bubble", 64'(o_valid), 64'd0);
    applyStimulus(1'b0, 1'b1, 32'h00441820, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    checkOutput("tp4_nostall", 64'(o_stall), 64'd0);
    advance();
    checkOutput("tp4_add_valid", 64'(o_valid), 64'd1);
    checkOutput("tp4_add_rs", 64'(o_rs), 64'd2);

    // Hold for three cycles, then hold together with flush.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 1'b1, rand_ins(), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      checkOutput("tp5_hold_stall", 64'(o_stall), 64'd1);
      advance();
      checkOutput("tp5_hold_rs", 64'(o_rs), 64'd2);
      checkOutput("tp5_hold_ex", 64'(o_ex), 64'h9);
    end
    applyStimulus(1'b0, 1'b1, 32'h00221820, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
    checkOutput("tp5_flush_stall", 64'(o_stall), 64'd1);
    advance();
    checkOutput("tp5_flush_valid", 64'(o_valid), 64'd0);
    checkOutput("tp5_flush_wb", 64'(o_wb), 64'd0);

    // Same-cycle write-back to r1, then a write to r0.
`ifdef ID_WB_BYPASS_EN
    exp_bypass = 32'hABCD;
`else
    exp_bypass = 32'd5;
`endif
    applyStimulus(1'b0, 1'b1, 32'h00221820, 1'b0, 1'b0, 1'b1, 5'd1, 32'hABCD); advance();
    checkOutput("tp6_bypass", 64'(o_rd1), 64'(exp_bypass));
    applyStimulus(1'b0, 1'b1, 32'h00001820, 1'b0, 1'b0, 1'b1, 5'd0, 32'd123); advance();
    checkOutput("tp6_r0_rd1", 64'(o_rd1), 64'd0);
    applyStimulus(1'b0, 1'b1, 32'h00221820, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0); advance();
    checkOutput("tp6_r1_new", 64'(o_rd1), 64'hABCD);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      applyStimulus(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 3) != 0), rand_ins(),
                    1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 9) == 0),
                    1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
